// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates the pipeline's instruction-fetch (IF) and
// data-memory (DM) ports onto a single external memory bus with a req/ack
// handshake. Round-robin between the two ports, one access at a time, with
// read-data capture, per-port stall outputs and a wait-state timeout.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-low reset
//   if_req/if_addr                  fetch request and address
//   if_rdata/if_done/if_stall       fetched word, completion pulse, stall
//   dm_req/dm_we/dm_addr/dm_wdata   data request, write enable, address, data
//   dm_rdata/dm_done/dm_stall       load data, completion pulse, stall
//   bus_req/bus_we/bus_addr/...     registered downstream request signals
//   bus_ack/bus_rdata               downstream completion and read data
//   bus_err                         sticky timeout flag
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access in flight; arbitrate and latch the winner's request
// ST_BUSY | bus_req high; wait for bus_ack or wait-state timeout
// ST_RESP | owner's done pulse is high; requests ignored this cycle
module mem_bus_arbiter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state;
    logic       last_grant;   // 0 = IF served last, 1 = DM served last
    logic       owner;        // 0 = IF, 1 = DM
    logic [7:0] wait_cnt;
    logic       grant_dm;

    // On a tie the port that was not served last wins.
    assign grant_dm = dm_req & (~if_req | ~last_grant);

    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            wait_cnt   <= 8'd0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            if_rdata   <= 32'd0;
            dm_rdata   <= 32'd0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (if_req || dm_req) begin
                        if (grant_dm) begin
                            bus_we    <= dm_we;
                            bus_addr  <= dm_addr;
                            bus_wdata <= dm_wdata;
                        end else begin
                            bus_we    <= 1'b0;
                            bus_addr  <= if_addr;
                            bus_wdata <= 32'd0;
                        end
                        bus_req    <= 1'b1;
                        wait_cnt   <= 8'd0;
                        owner      <= grant_dm;
                        last_grant <= grant_dm;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        if (!bus_we) begin
                            if (owner) dm_rdata <= bus_rdata;
                            else       if_rdata <= bus_rdata;
                        end
                        if (owner) dm_done <= 1'b1;
                        else       if_done <= 1'b1;
                        state <= ST_RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Timeout: complete the access with zero data.
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_err <= 1'b1;
                        if (owner) begin
                            dm_rdata <= 32'd0;
                            dm_done  <= 1'b1;
                        end else begin
                            if_rdata <= 32'd0;
                            if_done  <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset   = 1'b0;
        if_req  = 1'b0;
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        bus_ack = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        if_req = 1'b1;
        dm_req = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bus_req, bus_we, if_done, dm_done, bus_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b exp 00000", {bus_req, bus_we, if_done, dm_done, bus_err});
        end
        checks++;
        if ({bus_addr, bus_wdata, if_rdata, dm_rdata} !== 128'd0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h exp zeros", bus_addr, bus_wdata, if_rdata, dm_rdata);
        end
        checks++;
        if ({if_stall, dm_stall} !== 2'b10) begin
            errors++;
            $display("FAIL reset_stall: got %b exp 10", {if_stall, dm_stall});
        end
        if_req = 1'b0;
        reset  = 1'b1;
        tick();
    endtask

    task automatic test_if_fetch();
        if_req  = 1'b1;
        if_addr = 32'h0040_0000;
        tick();
        checks++;
        if ({bus_req, bus_we, bus_addr, if_stall, if_done} !== {1'b1, 1'b0, 32'h0040_0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fetch_busy: got req=%b we=%b addr=%h stall=%b done=%b exp 1 0 00400000 1 0",
                     bus_req, bus_we, bus_addr, if_stall, if_done);
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'h2408_000A;
        tick();
        checks++;
        if ({if_done, dm_done, bus_req, if_stall} !== 4'b1000 || if_rdata !== 32'h2408_000A) begin
            errors++;
            $display("FAIL fetch_done: got done=%b dm_done=%b req=%b stall=%b rdata=%h exp 1 0 0 0 2408000a",
                     if_done, dm_done, bus_req, if_stall, if_rdata);
        end
        if_req  = 1'b0;
        bus_ack = 1'b0;
        tick();
        checks++;
        if ({if_done, bus_req} !== 2'b00 || if_rdata !== 32'h2408_000A) begin
            errors++;
            $display("FAIL fetch_after: got done=%b req=%b rdata=%h exp 0 0 2408000a", if_done, bus_req, if_rdata);
        end
    endtask

    task automatic test_dm_write_waits();
        // a read first so the write's "rdata unchanged" check has a nonzero value
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h4000_0000;
        tick();
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        tick();
        checks++;
        if (dm_done !== 1'b1 || dm_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL dm_read: got done=%b rdata=%h exp 1 cafef00d", dm_done, dm_rdata);
        end
        dm_req  = 1'b0;
        bus_ack = 1'b0;
        tick();
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h4000_0010;
        dm_wdata = 32'h0000_0055;
        tick();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({bus_req, bus_we, bus_addr, bus_wdata, dm_done} !== {1'b1, 1'b1, 32'h4000_0010, 32'h55, 1'b0}) begin
                errors++;
                $display("FAIL dm_write_busy%0d: got req=%b we=%b addr=%h wdata=%h done=%b exp 1 1 40000010 00000055 0",
                         c, bus_req, bus_we, bus_addr, bus_wdata, dm_done);
            end
            dm_addr   = 32'hFFFF_FFFF;  // sampled only at grant
            bus_ack   = (c == 3);
            bus_rdata = 32'h1234_5678;
            tick();
        end
        checks++;
        if ({dm_done, if_done, bus_req, bus_we} !== 4'b1000 || dm_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL dm_write_done: got done=%b if_done=%b req=%b we=%b rdata=%h exp 1 0 0 0 cafef00d",
                     dm_done, if_done, bus_req, bus_we, dm_rdata);
        end
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        bus_ack = 1'b0;
        tick();
    endtask

    task automatic test_alternate();
        bit exp_busy, exp_if, exp_dm, turn_dm;
        apply_reset();
        if_req  = 1'b1;
        if_addr = 32'h0000_1000;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h8000_2000;
        for (int c = 0; c < 12; c++) begin
            turn_dm  = ((c / 3) % 2) == 1;
            exp_busy = (c % 3) == 1;
            exp_if   = (c % 3) == 2 && !turn_dm;
            exp_dm   = (c % 3) == 2 && turn_dm;
            checks++;
            if ({bus_req, if_done, dm_done} !== {exp_busy, exp_if, exp_dm}) begin
                errors++;
                $display("FAIL alt_cycle%0d: got req=%b if_done=%b dm_done=%b exp %b %b %b",
                         c, bus_req, if_done, dm_done, exp_busy, exp_if, exp_dm);
            end
            if (exp_busy) begin
                checks++;
                if (bus_addr !== (turn_dm ? 32'h8000_2000 : 32'h0000_1000)) begin
                    errors++;
                    $display("FAIL alt_addr%0d: got %h exp %h", c, bus_addr, turn_dm ? 32'h8000_2000 : 32'h0000_1000);
                end
            end
            if (exp_if || exp_dm) begin
                checks++;
                if ((turn_dm ? dm_rdata : if_rdata) !== 32'hA000_0000 + 32'(c - 1)) begin
                    errors++;
                    $display("FAIL alt_rdata%0d: got %h exp %h", c, turn_dm ? dm_rdata : if_rdata,
                             32'hA000_0000 + 32'(c - 1));
                end
            end
            bus_ack   = bus_req;
            bus_rdata = 32'hA000_0000 + 32'(c);
            tick();
        end
        if_req  = 1'b0;
        dm_req  = 1'b0;
        bus_ack = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL err_before: got %b exp 0", bus_err);
        end
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        bus_ack = 1'b0;
        tick();
        for (int c = 0; c < MAX_WAIT; c++) begin
            checks++;
            if ({bus_req, if_done} !== 2'b10) begin
                errors++;
                $display("FAIL to_busy%0d: got req=%b done=%b exp 1 0", c, bus_req, if_done);
            end
            tick();
        end
        checks++;
        if ({if_done, bus_req, bus_err} !== 3'b101 || if_rdata !== 32'd0) begin
            errors++;
            $display("FAIL to_done: got done=%b req=%b err=%b rdata=%h exp 1 0 1 00000000",
                     if_done, bus_req, bus_err, if_rdata);
        end
        if_req = 1'b0;
        tick();
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0080;
        tick();
        bus_ack   = 1'b1;
        bus_rdata = 32'h0BAD_BEEF;
        tick();
        checks++;
        if ({dm_done, bus_err} !== 2'b11 || dm_rdata !== 32'h0BAD_BEEF) begin
            errors++;
            $display("FAIL err_sticky: got done=%b err=%b rdata=%h exp 1 1 0badbeef", dm_done, bus_err, dm_rdata);
        end
        dm_req  = 1'b0;
        bus_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0100;
        tick();
        tick();
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got req=%b exp 1", bus_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus_req, dm_done, bus_err} !== 3'b000) begin
            errors++;
            $display("FAIL rst_async: got req=%b done=%b err=%b exp 0 0 0", bus_req, dm_done, bus_err);
        end
        bus_ack = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bus_req, dm_done} !== 2'b00) begin
            errors++;
            $display("FAIL rst_hold: got req=%b done=%b exp 0 0", bus_req, dm_done);
        end
        bus_ack = 1'b0;
        reset   = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        tick();
        checks++;
        if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h0000_0200}) begin
            errors++;
            $display("FAIL rst_tie: got req=%b we=%b addr=%h exp 1 0 00000200", bus_req, bus_we, bus_addr);
        end
        bus_ack = 1'b1;
        tick();
        checks++;
        if ({if_done, dm_done} !== 2'b10) begin
            errors++;
            $display("FAIL rst_tie_done: got if_done=%b dm_done=%b exp 1 0", if_done, dm_done);
        end
        if_req  = 1'b0;
        dm_req  = 1'b0;
        bus_ack = 1'b0;
        tick();
    endtask

    task automatic test_spurious_ack_and_drop();
        bus_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({bus_req, if_done, dm_done} !== 3'b000) begin
                errors++;
                $display("FAIL idle_ack%0d: got req=%b if_done=%b dm_done=%b exp 0 0 0", c, bus_req, if_done, dm_done);
            end
        end
        bus_ack = 1'b0;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0300;
        tick();
        dm_req = 1'b0;
        tick();
        checks++;
        if ({bus_req, dm_stall, dm_done} !== 3'b100) begin
            errors++;
            $display("FAIL drop_busy: got req=%b stall=%b done=%b exp 1 0 0", bus_req, dm_stall, dm_done);
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'h7777_0001;
        tick();
        checks++;
        if (dm_done !== 1'b1 || dm_rdata !== 32'h7777_0001) begin
            errors++;
            $display("FAIL drop_done: got done=%b rdata=%h exp 1 77770001", dm_done, dm_rdata);
        end
        bus_ack = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit          m_last_dm, m_err, ir, dr, own_dm, dwe, tmo, exp_we;
        logic [31:0] m_if_rd, m_dm_rd, ia, da, dwd, rd, exp_addr, exp_wd;
        int          w, busy_len;
        apply_reset();
        m_last_dm = 1'b1;
        m_err     = 1'b0;
        m_if_rd   = 32'd0;
        m_dm_rd   = 32'd0;
        for (int n = 0; n < 40; n++) begin
            ir  = ($urandom_range(0, 2) != 0);
            dr  = ir ? ($urandom_range(0, 1) == 1) : 1'b1;
            ia  = $urandom;
            da  = $urandom;
            dwd = $urandom;
            dwe = ($urandom_range(0, 1) == 1);
            rd  = $urandom;
            w   = $urandom_range(0, MAX_WAIT + 1);
            own_dm   = (ir && dr) ? !m_last_dm : dr;
            exp_we   = own_dm && dwe;
            exp_addr = own_dm ? da : ia;
            exp_wd   = own_dm ? dwd : 32'd0;
            tmo      = (w >= MAX_WAIT);
            busy_len = tmo ? MAX_WAIT : w + 1;
            if_req = ir; if_addr = ia;
            dm_req = dr; dm_addr = da; dm_wdata = dwd; dm_we = dwe;
            tick();
            for (int c = 0; c < busy_len; c++) begin
                checks++;
                if ({bus_req, bus_we, bus_addr, bus_wdata, if_done, dm_done} !==
                    {1'b1, exp_we, exp_addr, exp_wd, 2'b00}) begin
                    errors++;
                    $display("FAIL rnd%0d_busy%0d: got req=%b we=%b addr=%h wd=%h dn=%b%b exp 1 %b %h %h 00",
                             n, c, bus_req, bus_we, bus_addr, bus_wdata, if_done, dm_done, exp_we, exp_addr, exp_wd);
                end
                bus_ack   = (c == w);
                bus_rdata = rd;
                tick();
            end
            if (tmo) begin
                m_err = 1'b1;
                if (own_dm) m_dm_rd = 32'd0; else m_if_rd = 32'd0;
            end else if (!exp_we) begin
                if (own_dm) m_dm_rd = rd; else m_if_rd = rd;
            end
            m_last_dm = own_dm;
            checks++;
            if ({if_done, dm_done, bus_req, bus_we, bus_err} !== {!own_dm, own_dm, 2'b00, m_err} ||
                if_rdata !== m_if_rd || dm_rdata !== m_dm_rd) begin
                errors++;
                $display("FAIL rnd%0d_done: got dn=%b%b req=%b we=%b err=%b ird=%h drd=%h exp %b%b 0 0 %b %h %h",
                         n, if_done, dm_done, bus_req, bus_we, bus_err, if_rdata, dm_rdata,
                         !own_dm, own_dm, m_err, m_if_rd, m_dm_rd);
            end
            if_req  = 1'b0;
            dm_req  = 1'b0;
            bus_ack = ($urandom_range(0, 1) == 1);
            tick();
            checks++;
            if ({if_done, dm_done, bus_req} !== 3'b000) begin
                errors++;
                $display("FAIL rnd%0d_resp: got dn=%b%b req=%b exp 000", n, if_done, dm_done, bus_req);
            end
        end
        bus_ack = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_if_fetch();
        test_dm_write_waits();
        test_alternate();
        test_timeout();
        test_reset_mid_busy();
        test_spurious_ack_and_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
